// File: rtl/tpu_result_drain.sv
// tpu_result_drain: walks the C result buffer in address order and streams
// each 128-bit word to the host as 32-bit beats over valid/ready.
// Build option: TPU_DRAIN_SKIP_PAD_EN drops zero-padded lanes (columns >= N)
// in the last column tile. The default build emits all four lanes of every word.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start; M/N and word count captured on start
// RD     | C_rd_en high for one cycle at the current address
// CAP    | read data lands in the hold register, lane reset to 0
// SEND   | present hold lanes one per handshake
// DONE   | one-cycle done pulse, then back to IDLE
module tpu_result_drain #(
    parameter int ADDR_BITS  = 16,
    parameter int DATA_BITS  = 32,
    parameter int DATAC_BITS = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            M,
    input  logic [7:0]            N,
    output logic                  busy,
    output logic                  done,
    output logic                  C_rd_en,
    output logic [ADDR_BITS-1:0]  C_index,
    input  logic [DATAC_BITS-1:0] C_data_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_BITS-1:0]  out_data,
    output logic                  out_last
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_SEND,
        S_DONE
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_BITS-1:0]  addr;
    logic [ADDR_BITS-1:0]  words;
    logic [DATAC_BITS-1:0] hold;
    logic [1:0]            lane;
    logic [1:0]            last_lane;
    logic [6:0]            ntiles_in;
    logic [ADDR_BITS-1:0]  words_in;
    logic                  word_last;
    logic                  lane_last;
    logic                  hs;

    // ceil(N/4) column tiles; W = M * tiles fits in 16 bits for 8-bit M/N
    assign ntiles_in = 7'((9'(N) + 9'd3) >> 2);
    assign words_in  = ADDR_BITS'(M) * ADDR_BITS'(ntiles_in);
    assign word_last = (addr == words - ADDR_BITS'(1));
    assign hs        = (state == S_SEND) && out_ready;
    assign lane_last = (lane == last_lane);

`ifdef TPU_DRAIN_SKIP_PAD_EN
    logic [7:0] m_rows;
    logic [7:0] n_cols;
    logic [7:0] m_cnt;
    logic [6:0] ntiles;
    logic [6:0] ntile;

    // Only the last column tile is short: it ends at lane (N-1) mod 4
    assign last_lane = (ntile == ntiles - 7'd1) ? 2'(n_cols - 8'd1) : 2'd3;

    // Row/tile position of the current word; m wraps at M and bumps the tile
    always_ff @(posedge clk) begin
        if (rst) begin
            m_rows <= '0;
            n_cols <= '0;
            m_cnt  <= '0;
            ntiles <= '0;
            ntile  <= '0;
        end else if (state == S_IDLE && start) begin
            m_rows <= M;
            n_cols <= N;
            ntiles <= ntiles_in;
            m_cnt  <= '0;
            ntile  <= '0;
        end else if (hs && lane_last && !word_last) begin
            if (m_cnt == m_rows - 8'd1) begin
                m_cnt <= '0;
                ntile <= ntile + 7'd1;
            end else begin
                m_cnt <= m_cnt + 8'd1;
            end
        end
    end
`else
    assign last_lane = 2'd3;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (M == 8'd0 || N == 8'd0) ? S_DONE : S_RD;
                end
            end
            S_RD:   state_nxt = S_CAP;
            S_CAP:  state_nxt = S_SEND;
            S_SEND: begin
                if (hs && lane_last) begin
                    state_nxt = word_last ? S_DONE : S_RD;
                end
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Address, word count, hold register and lane pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            addr  <= '0;
            words <= '0;
            hold  <= '0;
            lane  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr  <= '0;
                        words <= words_in;
                    end
                end
                S_CAP: begin
                    hold <= C_data_out;
                    lane <= '0;
                end
                S_SEND: begin
                    if (out_ready) begin
                        if (lane_last) begin
                            if (!word_last) begin
                                addr <= addr + ADDR_BITS'(1);
                            end
                        end else begin
                            lane <= lane + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Moore outputs; lane 0 is the most significant 32 bits of the word
    always_comb begin
        busy      = (state == S_RD) || (state == S_CAP) || (state == S_SEND);
        done      = (state == S_DONE);
        C_rd_en   = (state == S_RD);
        C_index   = (state == S_RD) ? addr : '0;
        out_valid = (state == S_SEND);
        out_data  = '0;
        out_last  = 1'b0;
        if (state == S_SEND) begin
            out_data = hold[DATAC_BITS - 1 - DATA_BITS * int'(lane) -: DATA_BITS];
            out_last = lane_last && word_last;
        end
    end

endmodule

// File: tb/tb_tpu_result_drain.sv
// Self-checking bench for tpu_result_drain: directed vector table, a reset
// and restart sequence, and randomized drains against a column-order model.
module tb_tpu_result_drain;

`ifdef TPU_DRAIN_SKIP_PAD_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [7:0]   M_in;
    logic [7:0]   N_in;
    logic         busy;
    logic         done;
    logic         C_rd_en;
    logic [15:0]  C_index;
    logic [127:0] C_data_out = '0;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_last;

    int n_pass  = 0;
    int n_total = 0;
    int pat     = 0;
    int exp_words;
    logic [31:0] exp_q[$];

    typedef struct {
        int    m;
        int    n;
        int    rmode;
        int    pat;
        int    exp_beats;
        int    exp_busy;
        int    restart_at;
        string tag;
    } vec_t;

    vec_t vecs[8];

    tpu_result_drain dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .M          (M_in),
        .N          (N_in),
        .busy       (busy),
        .done       (done),
        .C_rd_en    (C_rd_en),
        .C_index    (C_index),
        .C_data_out (C_data_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] cval(int a, int l);
        if (pat == 0) return 32'(a * 4 + l);
        return (32'(a) * 32'h9E37_79B1) ^ (32'(l) * 32'h0100_0193) ^ 32'hA5C3_0000;
    endfunction

    function automatic logic [127:0] cword(int a);
        return {cval(a, 0), cval(a, 1), cval(a, 2), cval(a, 3)};
    endfunction

    // C buffer: data one cycle after the read strobe, junk otherwise
    always @(posedge clk) begin
        if (C_rd_en) C_data_out <= cword(int'(C_index));
        else         C_data_out <= {$urandom, $urandom, $urandom, $urandom};
    end

    // Expected beat stream in column order, straight from the layout rules
    function automatic void build_model(int m, int n);
        int ntiles;
        exp_q.delete();
        exp_words = 0;
        if (m == 0 || n == 0) return;
        ntiles = (n + 3) / 4;
        exp_words = m * ntiles;
        for (int t = 0; t < ntiles; t++)
            for (int r = 0; r < m; r++)
                for (int l = 0; l < 4; l++)
                    if (!(SKIP && (t * 4 + l >= n)))
                        exp_q.push_back(cval(t * m + r, l));
    endfunction

    function automatic int count_beats(int m, int n);
        if (SKIP) return m * n;
        return m * 4 * ((n + 3) / 4);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // Entered and left on a negedge; start is raised in cycle 0
    task automatic run_drain(input int m, input int n, input int rmode, input int pat_i,
                             input int exp_beats, input int exp_busy, input int restart_at,
                             input string tag);
        int cyc, beats, busy_cnt, done_cnt, done_cyc, first_v, last_hs, rd_cnt;
        logic rdy, prev_v, prev_r, prev_l;
        logic [31:0] prev_d, e;
        bit fin;
        pat = pat_i;
        build_model(m, n);
        M_in = 8'(m);
        N_in = 8'(n);
        start = 1'b1;
        out_ready = 1'b0;
        beats = 0; busy_cnt = 0; done_cnt = 0; done_cyc = -1; first_v = -1;
        last_hs = -1; rd_cnt = 0; prev_v = 0; prev_r = 0; prev_l = 0; prev_d = '0;
        fin = 0;
        @(negedge clk);
        cyc = 1;
        while (!fin && cyc < 3000) begin
            start = (cyc == restart_at);
            if (cyc == restart_at) begin
                M_in = 8'd1;
                N_in = 8'd1;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (C_rd_en) begin
                check({tag, " rd_index"}, 64'(C_index), 64'(rd_cnt));
                rd_cnt++;
            end
            if (prev_v && !prev_r) begin
                check({tag, " stall_valid"}, 64'(out_valid), 64'(1));
                check({tag, " stall_data"}, 64'(out_data), 64'(prev_d));
                check({tag, " stall_last"}, 64'(out_last), 64'(prev_l));
            end
            if (out_valid && first_v < 0) first_v = cyc;
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            out_ready = rdy;
            if (out_valid && rdy) begin
                if (exp_q.size() == 0) begin
                    check({tag, " beat_overrun"}, 64'(beats + 1), 64'(exp_beats));
                end else begin
                    e = exp_q.pop_front();
                    check({tag, " data"}, 64'(out_data), 64'(e));
                    check({tag, " last"}, 64'(out_last), 64'(exp_q.size() == 0));
                end
                beats++;
                last_hs = cyc;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                check({tag, " idle_after_done"}, 64'({busy, done, C_rd_en, out_valid}), 64'(0));
                fin = 1;
            end
            prev_v = out_valid;
            prev_r = rdy;
            prev_d = out_data;
            prev_l = out_last;
            if (!fin) begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        out_ready = 1'b0;
        check({tag, " done_pulses"}, 64'(done_cnt), 64'(1));
        check({tag, " beats"}, 64'(beats), 64'(exp_beats));
        check({tag, " leftover"}, 64'(exp_q.size()), 64'(0));
        check({tag, " reads"}, 64'(rd_cnt), 64'(exp_words));
        check({tag, " first_valid"}, 64'(first_v), 64'(exp_beats > 0 ? 3 : -1));
        check({tag, " done_cycle"}, 64'(done_cyc), 64'(exp_beats > 0 ? last_hs + 1 : 1));
        if (exp_busy >= 0) check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        M_in = '0;
        N_in = '0;
        out_ready = 1'b0;

        //          m  n    rmode pat beats                 busy                     restart tag
        vecs[0] = '{4, 4,   0,    0,  16,                   24,                      0,  "m4n4"};
        vecs[1] = '{5, 6,   0,    1,  SKIP ? 30 : 40,       SKIP ? 50 : 60,          0,  "m5n6"};
        vecs[2] = '{0, 8,   0,    0,  0,                    0,                       0,  "m0n8"};
        vecs[3] = '{4, 4,   1,    0,  16,                   -1,                      0,  "bp100"};
        vecs[4] = '{4, 4,   0,    1,  16,                   24,                      5,  "start_busy"};
        vecs[5] = '{4, 4,   0,    0,  16,                   24,                      25, "start_done"};
        vecs[6] = '{1, 1,   0,    1,  SKIP ? 1 : 4,         SKIP ? 3 : 6,            0,  "m1n1"};
        vecs[7] = '{3, 255, 0,    1,  SKIP ? 765 : 768,     SKIP ? 1149 : 1152,      0,  "m3n255"};

        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_rd_en", 64'(C_rd_en), 64'(0));
        check("reset_index", 64'(C_index), 64'(0));
        check("reset_valid", 64'(out_valid), 64'(0));
        check("reset_data", 64'(out_data), 64'(0));
        check("reset_last", 64'(out_last), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++)
            run_drain(vecs[i].m, vecs[i].n, vecs[i].rmode, vecs[i].pat,
                      vecs[i].exp_beats, vecs[i].exp_busy, vecs[i].restart_at, vecs[i].tag);

        // Reset while sending the word at address 2
        pat = 0;
        M_in = 8'd4;
        N_in = 8'd4;
        start = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        check("pre_reset_valid", 64'(out_valid), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        check("rst_ctrl", 64'({busy, done, C_rd_en, out_valid, out_last}), 64'(0));
        check("rst_index", 64'(C_index), 64'(0));
        check("rst_data", 64'(out_data), 64'(0));
        rst = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_done_after_rst", 64'({busy, done}), 64'(0));
        end
        run_drain(4, 4, 0, 0, 16, 24, 0, "after_rst");

        for (int i = 0; i < 20; i++) begin
            int m, n;
            m = $urandom_range(0, 6);
            n = $urandom_range(0, 13);
            run_drain(m, n, 2, 1, count_beats(m, n), -1, 0, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
